// File: rtl/snn_spike_classifier_pkg.sv
// Shared definitions for the spike classifier: default sizes, FSM encoding, id folding helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package snn_spike_classifier_pkg;

    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_TICK_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_CLEAR       = 2'd1,
        ST_COUNT       = 2'd2,
        ST_ARGMAX_DONE = 2'd3
    } state_e;

    // Sub-phase of ST_ARGMAX_DONE: walk the counters, then hold the result.
    typedef enum logic {
        PH_SCAN = 1'b0,
        PH_HOLD = 1'b1
    } phase_e;

    // Folds an 8-bit neuron id onto a class index with a shift/subtract chain.
    // The modulus is an elaboration constant, so every subtrahend is fixed.
    function automatic logic [7:0] id_mod(input logic [7:0] id, input int n);
        logic [15:0] r;
        r = {8'd0, id};
        for (int i = 7; i >= 0; i--) begin
            if (r >= 16'(n << i)) begin
                r = r - 16'(n << i);
            end
        end
        return 8'(r);
    endfunction

endpackage

// File: rtl/snn_spike_classifier_counter_bank.sv
// Per-class saturating spike counters with one increment port and one combinational read port.
// Latency: increment visible one cycle later; read is combinational.
// Backpressure: none; a saturated counter holds and raises the sticky sat flag until clear.
module spike_counter_bank #(
    parameter int NUM_CLASSES = 10,
    parameter int CNT_W       = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           clear,
    input  logic                           inc_en,
    input  logic [$clog2(NUM_CLASSES)-1:0] inc_idx,
    input  logic [$clog2(NUM_CLASSES)-1:0] rd_idx,
    output logic [CNT_W-1:0]               rd_dat,
    output logic                           sat
);

    localparam int IDX_W = $clog2(NUM_CLASSES);

    logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
    logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
    logic             sat_q;
    logic             sat_d;

    // Next counter values: clear wins, otherwise bump the addressed counter unless it is full.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clear) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                cnt_d[i] = '0;
            end
            sat_d = 1'b0;
        end else if (inc_en) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (IDX_W'(i) == inc_idx) begin
                    if (cnt_q[i] == {CNT_W{1'b1}}) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Counter and saturation state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                cnt_q[i] <= '0;
            end
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    // Read mux; indices past the last class read as zero.
    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (IDX_W'(i) == rd_idx) begin
                rd_dat = cnt_q[i];
            end
        end
    end

    assign sat = sat_q;

endmodule

// File: rtl/snn_spike_classifier.sv
// Counts output-neuron spikes per class over a frame of ticks, then reports the argmax class.
// Latency: result_valid NUM_CLASSES+1 cycles after the final-tick cycle.
// Backpressure: result held stable in HOLD until result_ready; start ignored while busy.
module snn_spike_classifier
    import snn_spike_classifier_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TICK_W      = DEF_TICK_W
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           tick,
    input  logic [7:0]                     packet_out,
    input  logic                           packet_out_valid,
    input  logic                           start,
    input  logic [TICK_W-1:0]              frame_ticks,
    output logic                           busy,
    output logic [$clog2(NUM_CLASSES)-1:0] result_class,
    output logic [CNT_W-1:0]               result_count,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic                           saturated
);

    localparam int IDX_W = $clog2(NUM_CLASSES);

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [TICK_W-1:0] ticks_q, ticks_d;
    logic [TICK_W-1:0] len_q, len_d;
    logic [TICK_W-1:0] ticks_inc;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0]  best_class_q, best_class_d;
    logic [CNT_W-1:0]  best_count_q, best_count_d;

    logic              bank_clear;
    logic              bank_inc;
    logic [IDX_W-1:0]  inc_idx;
    logic [CNT_W-1:0]  rd_dat;
    logic              bank_sat;

    assign inc_idx = IDX_W'(id_mod(packet_out, NUM_CLASSES));

    spike_counter_bank #(
        .NUM_CLASSES (NUM_CLASSES),
        .CNT_W       (CNT_W)
    ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (bank_clear),
        .inc_en  (bank_inc),
        .inc_idx (inc_idx),
        .rd_idx  (scan_idx_q),
        .rd_dat  (rd_dat),
        .sat     (bank_sat)
    );

    // Next-state logic: frame sequencing, tick counting and the one-class-per-cycle argmax scan.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        ticks_d      = ticks_q;
        len_d        = len_q;
        scan_idx_d   = scan_idx_q;
        best_class_d = best_class_q;
        best_count_d = best_count_q;
        bank_clear   = 1'b0;
        bank_inc     = 1'b0;
        ticks_inc    = ticks_q + TICK_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A zero-length frame would never terminate; run it as one tick.
                    len_d   = (frame_ticks == '0) ? TICK_W'(1) : frame_ticks;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                bank_clear   = 1'b1;
                ticks_d      = '0;
                scan_idx_d   = '0;
                best_class_d = '0;
                best_count_d = '0;
                phase_d      = PH_SCAN;
                state_d      = ST_COUNT;
            end
            ST_COUNT: begin
                // Spikes in the final-tick cycle still land before the scan reads them.
                bank_inc = packet_out_valid;
                if (tick) begin
                    ticks_d = ticks_inc;
                    if (ticks_inc == len_q) begin
                        state_d    = ST_ARGMAX_DONE;
                        phase_d    = PH_SCAN;
                        scan_idx_d = '0;
                    end
                end
            end
            ST_ARGMAX_DONE: begin
                if (phase_q == PH_SCAN) begin
                    // Class 0 seeds the best; later classes win only on a strictly larger count.
                    if (scan_idx_q == '0 || rd_dat > best_count_q) begin
                        best_class_d = scan_idx_q;
                        best_count_d = rd_dat;
                    end
                    if (scan_idx_q == IDX_W'(NUM_CLASSES - 1)) begin
                        phase_d = PH_HOLD;
                    end else begin
                        scan_idx_d = scan_idx_q + IDX_W'(1);
                    end
                end else if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_SCAN;
            ticks_q      <= '0;
            len_q        <= '0;
            scan_idx_q   <= '0;
            best_class_q <= '0;
            best_count_q <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            ticks_q      <= ticks_d;
            len_q        <= len_d;
            scan_idx_q   <= scan_idx_d;
            best_class_q <= best_class_d;
            best_count_q <= best_count_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_ARGMAX_DONE) && (phase_q == PH_HOLD);
    assign result_class = best_class_q;
    assign result_count = best_count_q;
    assign saturated    = bank_sat;

endmodule

// File: tb/tb_snn_spike_classifier.sv
// Scoreboard bench for snn_spike_classifier: directed frames push expected results,
// a negedge monitor pops and compares on every accepted result handshake.
module tb_snn_spike_classifier;

    logic       clk              = 1'b0;
    logic       reset_n          = 1'b0;
    logic       tick             = 1'b0;
    logic [7:0] packet_out       = 8'd0;
    logic       packet_out_valid = 1'b0;
    logic       start            = 1'b0;
    logic [7:0] frame_ticks      = 8'd0;
    logic       result_ready     = 1'b1;
    logic       busy;
    logic [3:0] result_class;
    logic [7:0] result_count;
    logic       result_valid;
    logic       saturated;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cls;
        int cnt;
        int sat;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    snn_spike_classifier #(
        .NUM_CLASSES (10),
        .CNT_W       (8),
        .TICK_W      (8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .tick             (tick),
        .packet_out       (packet_out),
        .packet_out_valid (packet_out_valid),
        .start            (start),
        .frame_ticks      (frame_ticks),
        .busy             (busy),
        .result_class     (result_class),
        .result_count     (result_count),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .saturated        (saturated)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic push_exp(input int cls, input int cnt, input int sat);
        exp_t e;
        e.cls = cls;
        e.cnt = cnt;
        e.sat = sat;
        exp_q.push_back(e);
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then wait through CLEAR so the next driven cycle is in COUNT.
    task automatic start_frame(input int ft);
        start       = 1'b1;
        frame_ticks = 8'(ft);
        step();
        start = 1'b0;
        step();
    endtask

    task automatic spikes(input int id, input int n);
        packet_out       = 8'(id);
        packet_out_valid = 1'b1;
        repeat (n) step();
        packet_out_valid = 1'b0;
    endtask

    // Final tick (with whatever spike is already driven), then measure cycles to result_valid.
    task automatic final_tick(input string name);
        int lat;
        tick = 1'b1;
        step();
        tick             = 1'b0;
        packet_out_valid = 1'b0;
        lat = 1;
        while (!result_valid && lat < 100) begin
            step();
            lat++;
        end
        chk(name, lat, 11);
    endtask

    // Monitor: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("result_class", int'(result_class), e.cls);
                chk("result_count", int'(result_count), e.cnt);
                chk("saturated", int'(saturated), e.sat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        reset_n = 1'b0;
        repeat (2) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_class", int'(result_class), 0);
        chk("rst_count", int'(result_count), 0);
        chk("rst_sat", int'(saturated), 0);
        reset_n = 1'b1;
        step();

        // Tie between classes 2 and 7 resolves to the lower index.
        push_exp(2, 4, 0);
        start_frame(1);
        chk("busy_in_frame", int'(busy), 1);
        spikes(2, 4);
        spikes(7, 4);
        final_tick("tie_latency");
        step();

        // 300 spikes on class 3 saturate its counter at 255.
        push_exp(3, 255, 1);
        start_frame(1);
        spikes(3, 300);
        final_tick("sat_latency");
        step();

        // Empty frame with frame_ticks=0 behaves as one tick.
        push_exp(0, 0, 0);
        start_frame(0);
        final_tick("empty_latency");
        step();

        // Hold with result_ready low while spikes and start pulses arrive.
        result_ready = 1'b0;
        push_exp(4, 2, 0);
        start_frame(1);
        spikes(4, 2);
        final_tick("hold_latency");
        for (int i = 0; i < 20; i++) begin
            packet_out       = 8'd15;
            packet_out_valid = 1'b1;
            start            = i[0];
            step();
            chk("hold_valid", int'(result_valid), 1);
            chk("hold_class", int'(result_class), 4);
            chk("hold_count", int'(result_count), 2);
        end
        packet_out_valid = 1'b0;
        start            = 1'b0;
        result_ready     = 1'b1;
        step();
        chk("post_xfer_valid", int'(result_valid), 0);
        chk("post_xfer_busy", int'(busy), 0);
        chk("post_xfer_class_kept", int'(result_class), 4);

        // The following frame must start from cleared counters.
        push_exp(9, 1, 0);
        start_frame(1);
        spikes(9, 1);
        final_tick("after_hold_latency");
        step();

        // Spike on the third (final) tick is counted: id 25 folds to class 5.
        push_exp(5, 1, 0);
        start_frame(3);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        tick = 1'b1;
        step();
        tick             = 1'b0;
        packet_out       = 8'd25;
        packet_out_valid = 1'b1;
        final_tick("final_tick_latency");
        step();

        // Reset mid-frame abandons the frame; the monitor flags any result that appears.
        start_frame(5);
        spikes(6, 5);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(result_valid), 0);
        repeat (15) begin
            step();
            chk("midrst_no_result", int'(result_valid), 0);
        end

        push_exp(1, 2, 0);
        start_frame(1);
        spikes(6, 1);
        spikes(1, 2);
        final_tick("after_rst_latency");
        step();

        repeat (5) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
